// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back path: the write request record
// and the register-zero constant.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_req_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic [31:0] reg_onehot(input logic [4:0] a);
    return 32'd1 << a;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline, long-latency and register-file write-port signals
// around rf_wb_arbiter.
interface rf_wb_arbiter_if;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] w_pc;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [31:0] lu_pc;
  logic        rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_pc;
  logic        wb_stall;
  logic [31:0] busy_mask;

  modport master (
    output w_we, w_addr, w_data, w_pc,
    output lu_valid, lu_addr, lu_data, lu_pc,
    input  lu_ready,
    input  rf_wr, rf_a3, rf_wd, rf_pc,
    input  wb_stall, busy_mask
  );

  modport slave (
    input  w_we, w_addr, w_data, w_pc,
    input  lu_valid, lu_addr, lu_data, lu_pc,
    output lu_ready,
    output rf_wr, rf_a3, rf_wd, rf_pc,
    output wb_stall, busy_mask
  );
endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Long-latency result queue: circular buffer with extra-bit pointers and a
// per-entry address/valid view used to build the pending-write scoreboard.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  wb_req_t            push_req,
  input  logic               pop,
  output wb_req_t            head,
  output logic               full,
  output logic               empty,
  output logic [DEPTH*5-1:0] ent_addr,
  output logic [DEPTH-1:0]   ent_vld
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = 1;

  wb_req_t        mem [DEPTH];
  logic [IDX_W:0] wr_ptr, rd_ptr, count;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[IDX_W-1:0]] <= push_req;
  end

  // An entry is live when its distance from the read pointer is below occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [IDX_W-1:0] rel;
    assign rel                = IDX_W'(g) - rd_ptr[IDX_W-1:0];
    assign ent_vld[g]         = ({1'b0, rel} < count);
    assign ent_addr[g*5 +: 5] = mem[g].addr;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port driver: merges in-order W-stage writes with queued
// long-latency results. Define WB_TRACE_EN to print each register write.
module rf_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic           clk,
  input logic           reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_req_t            lu_req, w_req, head, req_nxt, req_p1;
  logic               push, pop, full, empty, w_live;
  logic               wr_nxt, wr_p1, stall_nxt, stall_p1;
  logic [CNT_W-1:0]   cnt_nxt, cnt_p1;
  logic [DEPTH*5-1:0] ent_addr;
  logic [DEPTH-1:0]   ent_vld;
  logic [31:0]        busy;

  assign lu_req       = {bus.lu_addr, bus.lu_data, bus.lu_pc};
  assign w_req        = {bus.w_addr, bus.w_data, bus.w_pc};
  assign w_live       = bus.w_we && (bus.w_addr != REG_ZERO);
  assign bus.lu_ready = reset && !full;
  // Writes to r0 are acknowledged but never occupy a queue slot.
  assign push         = bus.lu_valid && bus.lu_ready && (bus.lu_addr != REG_ZERO);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_req (lu_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .ent_addr (ent_addr),
    .ent_vld  (ent_vld)
  );

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) busy = busy | reg_onehot(ent_addr[i*5 +: 5]);
    end
    busy[0] = 1'b0;
  end
  assign bus.busy_mask = busy;

  always_comb begin
    pop     = 1'b0;
    wr_nxt  = 1'b0;
    req_nxt = req_p1;
    if (stall_p1 && !empty) begin
      pop     = 1'b1;
      wr_nxt  = 1'b1;
      req_nxt = head;
    end else if (w_live) begin
      wr_nxt  = 1'b1;
      req_nxt = w_req;
    end else if (!empty) begin
      pop     = 1'b1;
      wr_nxt  = 1'b1;
      req_nxt = head;
    end

    if (pop || empty)         cnt_nxt = '0;
    else if (cnt_p1 < CNT_MAX) cnt_nxt = cnt_p1 + CNT_ONE;
    else                      cnt_nxt = cnt_p1;

    // Reaching the limit implies no pop this cycle, so the forced drain next
    // cycle drops the counter and this flag together.
    stall_nxt = (cnt_nxt == CNT_MAX);
  end

  // ---- stage p1: registered write port and starvation state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_p1    <= 1'b0;
      req_p1   <= '0;
      cnt_p1   <= '0;
      stall_p1 <= 1'b0;
    end else begin
      wr_p1    <= wr_nxt;
      req_p1   <= req_nxt;
      cnt_p1   <= cnt_nxt;
      stall_p1 <= stall_nxt;
    end
  end

  assign bus.rf_wr    = wr_p1;
  assign bus.rf_a3    = req_p1.addr;
  assign bus.rf_wd    = req_p1.data;
  assign bus.rf_pc    = req_p1.pc;
  assign bus.wb_stall = stall_p1;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (bus.rf_wr) $display("%d@%h: $%d <= %h", $time, bus.rf_pc, bus.rf_a3, bus.rf_wd);
  end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port driver for the 32×32 register file. It merges two result sources onto the single register-file write port: in-order W-stage results from the main pipeline, and out-of-order results from long-latency units (mult/div, cache-miss loads), which arrive through a valid/ready queue. It drives the register file's write-enable, address, data and trace-PC inputs from registered outputs. It also exports a pending-write scoreboard so decode can stall on registers whose queued writes have not yet landed.

## Interface
- `DEPTH`, 4: long-latency result queue entries (power of two, ≥2)
- `STARVE_MAX`, 8: consecutive cycles a non-empty queue may be denied the port before `wb_stall` is raised
- `clk` input 1: clock, all state on rising edge
- `reset` input 1: asynchronous, active-low reset
- `w_we` input 1: pipeline W-stage write request
- `w_addr` input 5: pipeline destination register
- `w_data` input 32: pipeline write data
- `w_pc` input 32: pipeline instruction PC (trace)
- `lu_valid` input 1: long-latency result offered
- `lu_ready` output 1: queue can accept (`reset` high and queue not full)
- `lu_addr` input 5: long-latency destination
- `lu_data` input 32: long-latency data
- `lu_pc` input 32: long-latency instruction PC
- `rf_wr` output 1: register-file write enable
- `rf_a3` output 5: register-file write address
- `rf_wd` output 32: register-file write data
- `rf_pc` output 32: PC of the write being performed
- `wb_stall` output 1: pipeline must freeze and hold its W-stage inputs
- `busy_mask` output 32: bit r set when any queued entry targets r (bit 0 always 0)

## Operation
- **Queue.** Circular FIFO with `DEPTH` entries, read/write pointers one bit wider than the index.
  - Push on `lu_valid && lu_ready`.
  - Entries with `lu_addr==0` are accepted but not enqueued (dropped).
  - No pass-through path: a pushed entry is visible at the head no earlier than the next cycle.
- **Arbitration each cycle**, where `w_live = w_we && w_addr!=0`:
  - `wb_stall==1` and queue non-empty: pop the head into the output register. Pipeline inputs are ignored; upstream holds them.
  - else `w_live`: load the pipeline write into the output register.
  - else queue non-empty: pop the head into the output register.
  - else: the output register loads `rf_wr=0`, and address, data and PC hold their values.
- **Starvation counter.**
  - Increments when the queue is non-empty and no pop occurs.
  - Clears on any pop or when the queue is empty; saturates at `STARVE_MAX`.
  - `wb_stall` is a register. It is set on the edge where the counter reaches `STARVE_MAX` and cleared on the edge of the pop it forces, so it is high for exactly one cycle per forced drain.
- **Scoreboard.** `busy_mask` is the combinational OR of one-hot decodes of every valid queue entry's address. An entry's bit drops in the cycle after its pop, which is the cycle it is presented on `rf_wr`; the register file's internal write-to-read bypass covers that cycle.
- **Full/empty and simultaneous events.**
  - Push and pop in the same cycle are allowed whenever not full.
  - When full, `lu_ready=0` and the occupancy is unchanged by `lu_valid`.
- **Ordering contract.** Decode must not issue an instruction whose destination has its `busy_mask` bit set. The block does not reorder WAW pairs.

## Timing
- Pipeline write presented in cycle N appears on `rf_*` in N+1.
- Queue push in cycle N appears on `rf_*` in N+2 at the earliest.
- Worst-case wait of a head entry under continuous pipeline writes: `STARVE_MAX`+2 cycles.
- **Reset asserted** (asynchronous, mid-operation included):
  - `rf_wr=0`, `rf_a3=0`, `rf_wd=0`, `rf_pc=0`.
  - `wb_stall=0`, `lu_ready=0`, `busy_mask=0`.
  - Queue emptied and counter cleared; in-flight entries are discarded.
- `lu_ready` rises in the first cycle after reset deasserts.

## Configuration
- `WB_TRACE_EN` defined: on every rising edge where `rf_wr==1`, the block prints `"%d@%h: $%d <= %h"` with `$time`, `rf_pc`, `rf_a3`, `rf_wd`. The register file's own print must then be disabled.
- Undefined: no simulation output; the RTL is otherwise identical.

## Structure
- Shared package `wb_pkg`:
  - typedef `wb_req_t` {addr[4:0], data[31:0], pc[31:0]}
  - constant `REG_ZERO=5'd0`
- One sub-module `wb_fifo`: storage, pointers, `full`/`empty`, and a flattened entry-address/valid view for the scoreboard.
- Arbitration, starvation counter and output register live in the top module.

## Test plan
- Pipeline `w_we=1`, `w_addr=5`, `w_data=0x1234`, `w_pc=0x3000` at N -> `rf_wr=1`, `rf_a3=5`, `rf_wd=0x1234`, `rf_pc=0x3000` at N+1; `busy_mask=0` throughout.
- Push `lu_addr=9`, `lu_data=0xDEAD` with the pipeline idle -> `busy_mask[9]=1` from N+1; `rf_a3=9`, `rf_wd=0xDEAD` at N+2; `busy_mask[9]=0` at N+2.
- Push five entries with `DEPTH=4` while the pipeline writes every cycle -> `lu_ready=0` after the fourth push; fifth held. `wb_stall` high for one cycle after 8 denied cycles, head written that cycle+1, then the fifth push is accepted.
- `w_addr=0` with `w_we=1` and queue holding `r3` -> queue entry drains; no write to r0. `lu_addr=0` push -> accepted, `busy_mask` unchanged, no `rf_wr`.
- Push and pop in the same cycle with 2 entries queued -> occupancy stays 2; FIFO order preserved across pointer wrap.
- Assert `reset` low mid-drain with 3 queued -> all outputs 0 asynchronously; after release, no stale writes and `lu_ready=1`.
